// File: rtl/alu_muldiv_pkg.sv
// Shared ALU definitions: function codes and the mul/div sequencer states.
package alu_muldiv_pkg;

  typedef enum logic [3:0] {
    AluFuncAdd   = 4'd0,
    AluFuncSub   = 4'd1,
    AluFuncAnd   = 4'd2,
    AluFuncOr    = 4'd3,
    AluFuncXor   = 4'd4,
    AluFuncSlt   = 4'd5,
    AluFuncMult  = 4'd6,
    AluFuncMultu = 4'd7,
    AluFuncDiv   = 4'd8,
    AluFuncDivu  = 4'd9
  } alu_func_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } muldiv_state_e;

  function automatic logic is_muldiv(alu_func_e func);
    return (func == AluFuncMult) || (func == AluFuncMultu) ||
           (func == AluFuncDiv)  || (func == AluFuncDivu);
  endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One combinational iteration: radix-2 shift-add multiply or restoring divide.
module alu_muldiv_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0]   i_operand,
  input  logic                i_is_div,
  output logic [2*DATA_W-1:0] o_acc,
  output logic                o_q_bit
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_rem_sh;
  logic [DATA_W:0] w_diff;

  always_comb begin
    w_sum    = {1'b0, i_acc[2*DATA_W-1:DATA_W]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    // Partial remainder shifted left with the next dividend bit appended.
    w_rem_sh = i_acc[2*DATA_W-1:DATA_W-1];
    w_diff   = w_rem_sh - {1'b0, i_operand};
    o_q_bit  = 1'b0;
    o_acc    = {w_sum, i_acc[DATA_W-1:1]};
    if (i_is_div) begin
      o_q_bit = ~w_diff[DATA_W];
      o_acc   = {(o_q_bit ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0]),
                 i_acc[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit feeding HI/LO; fixed DATA_W+2 cycle latency.
// Optional ALU_MULDIV_EARLY_OUT_EN: multiplies finish once remaining multiplier bits are zero.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  alu_func_e         i_func,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  muldiv_state_e       r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_op;
  logic                r_is_div;
  logic                r_neg_res;
  logic                r_neg_rem;
  logic                r_div_zero;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;

  logic                w_is_signed;
  logic                w_is_div;
  logic                w_sign1;
  logic                w_sign2;
  logic [DATA_W-1:0]   w_abs1;
  logic [DATA_W-1:0]   w_abs2;
  logic [2*DATA_W-1:0] w_step_acc;
  logic                w_q_bit;
  logic [2*DATA_W-1:0] w_next_acc;
  logic [2*DATA_W-1:0] w_calc_acc;
  logic                w_calc_last;
  logic [2*DATA_W-1:0] w_prod_fix;
  logic [DATA_W-1:0]   w_quo_fix;
  logic [DATA_W-1:0]   w_rem_fix;
  logic [DATA_W-1:0]   w_fix_hi;
  logic [DATA_W-1:0]   w_fix_lo;
`ifdef ALU_MULDIV_EARLY_OUT_EN
  logic [DATA_W-1:0]   w_rem_mask;
`endif

  alu_muldiv_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .i_acc    (r_acc),
    .i_operand(r_op),
    .i_is_div (r_is_div),
    .o_acc    (w_step_acc),
    .o_q_bit  (w_q_bit)
  );

  always_comb begin
    w_is_signed = (i_func == AluFuncMult) || (i_func == AluFuncDiv);
    w_is_div    = (i_func == AluFuncDiv) || (i_func == AluFuncDivu);
    w_sign1     = w_is_signed & i_data1[DATA_W-1];
    w_sign2     = w_is_signed & i_data2[DATA_W-1];
    w_abs1      = w_sign1 ? -i_data1 : i_data1;
    w_abs2      = w_sign2 ? -i_data2 : i_data2;
  end

  always_comb begin
    w_next_acc  = {w_step_acc[2*DATA_W-1:1], w_step_acc[0] | w_q_bit};
    w_calc_acc  = w_next_acc;
    w_calc_last = (r_cnt == CNT_W'(1));
`ifdef ALU_MULDIV_EARLY_OUT_EN
    // Low r_cnt-1 bits of the accumulator still hold unprocessed multiplier bits.
    w_rem_mask = (DATA_W'(1) << (r_cnt - CNT_W'(1))) - DATA_W'(1);
    if (!r_is_div && ((w_next_acc[DATA_W-1:0] & w_rem_mask) == '0)) begin
      w_calc_acc  = w_next_acc >> (r_cnt - CNT_W'(1));
      w_calc_last = 1'b1;
    end
`endif
  end

  always_comb begin
    w_prod_fix = r_neg_res ? -r_acc : r_acc;
    w_quo_fix  = r_neg_res ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    if (r_div_zero) begin
      w_quo_fix = '1;
    end
    w_rem_fix = r_neg_rem ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
    w_fix_hi  = r_is_div ? w_rem_fix : w_prod_fix[2*DATA_W-1:DATA_W];
    w_fix_lo  = r_is_div ? w_quo_fix : w_prod_fix[DATA_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_op       <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
          if (i_start && !i_flush && is_muldiv(i_func)) begin
            r_state    <= StCalc;
            r_busy     <= 1'b1;
            r_cnt      <= CNT_W'(DATA_W);
            r_is_div   <= w_is_div;
            r_neg_res  <= w_sign1 ^ w_sign2;
            r_neg_rem  <= w_sign1;
            r_div_zero <= w_is_div && (i_data2 == '0);
            r_acc      <= {{DATA_W{1'b0}}, (w_is_div ? w_abs1 : w_abs2)};
            r_op       <= w_is_div ? w_abs2 : w_abs1;
`ifdef ALU_MULDIV_EARLY_OUT_EN
            if (!w_is_div && (w_abs2 == '0)) begin
              r_state <= StFix;
            end
`endif
          end
        end
        StCalc: begin
          if (i_flush) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_calc_acc;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_calc_last) begin
              r_state <= StFix;
            end
          end
        end
        StFix: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          if (!i_flush) begin
            r_state <= StDone;
            r_done  <= 1'b1;
            r_hi    <= w_fix_hi;
            r_lo    <= w_fix_lo;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv at DATA_W=4; honours ALU_MULDIV_EARLY_OUT_EN for latency.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           k;
    int           gap;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  alu_func_e    func;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  exp_t         sb[$];
  int           cyc;
  int           n_pass;
  int           n_total;
  logic [W-1:0] last_hi;
  logic [W-1:0] last_lo;

  alu_muldiv #(
    .DATA_W(W)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .i_func (func),
    .i_data1(d1),
    .i_data2(d2),
    .i_flush(flush),
    .o_busy (busy),
    .o_done (done),
    .o_hi   (hi),
    .o_lo   (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // Edges from the start-sampling edge to the edge that raises done.
  function automatic int exp_gap(input alu_func_e f, input logic [W-1:0] b);
    logic [W-1:0] m;
    int           n;
    m = (f == AluFuncMult && b[W-1]) ? -b : b;
    n = 0;
    for (int i = 0; i < W; i++) begin
      if (m[i]) n = i + 1;
    end
`ifdef ALU_MULDIV_EARLY_OUT_EN
    if (f == AluFuncMult || f == AluFuncMultu) return n + 1;
`endif
    return W + 1;
  endfunction

  // Caller is positioned just after a clock edge; returns just after the sampling edge.
  task automatic issue(input alu_func_e f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input bit push);
    exp_t e;
    start = 1'b1;
    func  = f;
    d1    = a;
    d2    = b;
    if (push) begin
      e.hi  = eh;
      e.lo  = el;
      e.k   = cyc + 1;
      e.gap = exp_gap(f, b);
      sb.push_back(e);
      last_hi = eh;
      last_lo = el;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain();
    bit timed_out;
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && !busy && !done) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", int'(timed_out), 0);
  endtask

  task automatic run(input alu_func_e f, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eh, input logic [W-1:0] el);
    issue(f, a, b, eh, el, 1'b1);
    drain();
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", int'(hi), int'(e.hi));
        chk("lo", int'(lo), int'(e.lo));
        chk("latency", cyc - e.k, e.gap);
      end
    end
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    last_hi = '0;
    last_lo = '0;
    rst     = 1'b1;
    start   = 1'b0;
    func    = AluFuncAdd;
    d1      = '0;
    d2      = '0;
    flush   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_hi", int'(hi), 0);
    chk("rst_lo", int'(lo), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // First op: busy through CALC and FIX, then a one-cycle done.
    issue(AluFuncMultu, 4'hA, 4'hA, 4'h6, 4'h4, 1'b1);
    for (int i = 0; i <= W; i++) begin
      chk("busy_during_op", int'(busy), 1);
      @(posedge clk);
      #1;
    end
    chk("busy_in_done", int'(busy), 0);
    chk("done_pulse", int'(done), 1);
    @(posedge clk);
    #1;
    chk("done_single", int'(done), 0);
    drain();

    run(AluFuncMult,  4'hD, 4'h5, 4'hF, 4'h1);
    run(AluFuncDivu,  4'h7, 4'h3, 4'h1, 4'h2);
    run(AluFuncDiv,   4'h9, 4'h2, 4'hF, 4'hD);
    run(AluFuncDivu,  4'h7, 4'h0, 4'h7, 4'hF);
    run(AluFuncDiv,   4'h8, 4'hF, 4'h0, 4'h8);
    run(AluFuncMult,  4'hF, 4'hF, 4'h0, 4'h1);
    run(AluFuncMultu, 4'hF, 4'hF, 4'hE, 4'h1);
    run(AluFuncDiv,   4'h7, 4'hE, 4'h1, 4'hD);
    run(AluFuncDiv,   4'h9, 4'hB, 4'hE, 4'h1);
    run(AluFuncMultu, 4'h3, 4'h1, 4'h0, 4'h3);
    run(AluFuncMultu, 4'h6, 4'h0, 4'h0, 4'h0);

    // Non-mul/div func and start accompanied by flush are both ignored.
    issue(AluFuncAdd, 4'h3, 4'h3, 4'h0, 4'h0, 1'b0);
    chk("ignore_func_busy", int'(busy), 0);
    flush = 1'b1;
    issue(AluFuncMultu, 4'h3, 4'h3, 4'h0, 4'h0, 1'b0);
    flush = 1'b0;
    chk("ignore_flush_start_busy", int'(busy), 0);
    drain();

    // Start while busy must not disturb the op in flight.
    issue(AluFuncDivu, 4'hB, 4'h3, 4'h2, 4'h3, 1'b1);
    @(posedge clk);
    #1;
    issue(AluFuncMultu, 4'h3, 4'h3, 4'h0, 4'h0, 1'b0);
    drain();

    // Flush on the third busy cycle.
    issue(AluFuncMultu, 4'h5, 4'hF, 4'h0, 4'h0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", int'(busy), 0);
    for (int i = 0; i < W + 3; i++) begin
      chk("flush_no_done", int'(done), 0);
      @(posedge clk);
      #1;
    end
    chk("flush_hi_kept", int'(hi), int'(last_hi));
    chk("flush_lo_kept", int'(lo), int'(last_lo));

    // Back-to-back: second start issued in the DONE cycle.
    issue(AluFuncDivu, 4'hB, 4'h2, 4'h1, 4'h5, 1'b1);
    repeat (W + 1) begin
      @(posedge clk);
      #1;
    end
    chk("b2b_in_done", int'(done), 1);
    issue(AluFuncDiv, 4'h9, 4'h2, 4'hF, 4'hD, 1'b1);
    drain();

    // Reset in the middle of CALC.
    issue(AluFuncMultu, 4'h7, 4'hF, 4'h0, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_hi", int'(hi), 0);
    chk("midrst_lo", int'(lo), 0);
    run(AluFuncDivu, 4'hF, 4'h4, 4'h3, 4'h3);

    repeat (W + 3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Iterative multi-cycle multiply/divide unit.
- Sits beside the ALU in the execute stage and feeds the HI/LO register file with the 2×DATA_W product, or with the quotient and remainder.
- Accepts one operation per start pulse and reports busy and done to the hazard/stall logic.
- The HI/LO consumer writes hi/lo on the done pulse.

Parameters:
- DATA_W, 32, operand width; hi and lo are each DATA_W bits.
- CNT_W, $clog2(DATA_W+1), width of the iteration counter (derived; do not override).

Ports:
- ctrl  in  `Util_Control_T`  shared control bundle. `Util_Control_clock(ctrl)` is the single clock. `Util_Control_reset(ctrl)` is the reset: synchronous, active-high.
- start  in  1  request an operation this cycle.
- func  in  `Alu_Func_T`  operation; only `Alu_Func_Mult`, `Alu_Func_Multu`, `Alu_Func_Div`, `Alu_Func_Divu` are acted on.
- data1  in  DATA_W  multiplicand / dividend.
- data2  in  DATA_W  multiplier / divisor.
- flush  in  1  cancel the operation in flight (pipeline flush).
- busy  out  1  operation in progress; stall any dependent mfhi/mflo.
- done  out  1  single-cycle pulse; hi/lo valid.
- hi  out  DATA_W  product upper half / remainder.
- lo  out  DATA_W  product lower half / quotient.

Behaviour:
- Reset (sync, on clock edge with reset=1): state IDLE; busy=0, done=0, hi=0, lo=0, counter=0. Reset overrides start and flush on the same edge.
- States: IDLE → CALC → FIX → DONE → IDLE.
- IDLE:
  - start=1 with a mul/div func: latch |data1|, |data2| (absolute values only for signed funcs), latch the result signs, load counter=DATA_W, go to CALC.
  - start=1 with any other func is ignored.
- CALC, one iteration per cycle, counter decrements, go to FIX when the counter reaches 0:
  - Multiply: radix-2 shift-add on a 2×DATA_W accumulator.
  - Divide: restoring shift-subtract.
- FIX: one cycle; apply two's-complement sign correction.
  - Signed multiply: product negated if operand signs differ.
  - Signed divide: quotient negated if signs differ; remainder takes the sign of the dividend (truncating division).
  - Register hi/lo at the end of FIX.
- DONE: done=1 for exactly one cycle, busy=0. A start in DONE is accepted exactly as in IDLE (back-to-back operations).
- busy=1 in CALC and FIX only.
- Latency: start sampled at edge k → done high during the cycle after edge k+DATA_W+1. That is DATA_W+2 cycles, fixed.
- hi/lo hold their last completed result until the next FIX; they never change mid-operation.
- start while busy is ignored; no queueing.
- flush=1 in CALC or FIX: return to IDLE at the next edge, busy=0, no done, hi/lo unchanged. flush in IDLE/DONE has no effect; an accompanying start is still ignored that edge.
- Divide by zero (data2=0): completes with normal latency, hi=data1, lo={DATA_W{1'b1}}. No exception.
- Signed overflow: most-negative / -1 gives lo=most-negative, hi=0 (wraps).
- All arithmetic is modulo DATA_W per half; the multiply product is exact in 2×DATA_W.

Optional Feature:
- Macro ALU_MULDIV_EARLY_OUT_EN.
- Defined: in CALC during a multiply, when the remaining unprocessed multiplier bits are all zero, shift the accumulator by the remaining count in one step and go straight to FIX. Latency is 2 + number of iterations actually run, minimum 2 for data2=0. Divides are unaffected.
- Undefined: fixed DATA_W+2 latency for all operations.

Decomposition:
- Add the state encoding (IDLE/CALC/FIX/DONE) to the shared Alu definitions, alongside the `Alu_Func_*` macros.
- Add `Alu_Func_Mult/Multu/Div/Divu` if absent.
- One sub-module: alu_muldiv_step, a combinational single iteration. Inputs: accumulator, operand, mode. Outputs: next accumulator and quotient bit. The FSM/counter stays in alu_muldiv.

Test Plan:
- DATA_W=4, Multu, data1=4'hA, data2=4'hA → 6 cycles later done=1, hi=4'h6, lo=4'h4; busy high for the intervening cycles.
- Mult, data1=4'hD (-3), data2=4'h5 → hi=4'hF, lo=4'h1 (-15).
- Divu 7/3 → lo=4'h2, hi=4'h1. Div, data1=4'h9 (-7), data2=4'h2 → lo=4'hD (-3), hi=4'hF (-1).
- Divu data2=0, data1=4'h7 → hi=4'h7, lo=4'hF. Div 4'h8 / 4'hF → lo=4'h8, hi=4'h0.
- Start Multu, assert flush on the 3rd busy cycle → busy=0 next cycle, no done, hi/lo keep previous values. Reset asserted mid-CALC → all outputs 0 after the edge.
- Back-to-back: start asserted in the DONE cycle → second op accepted, its done exactly DATA_W+2 cycles later. Start while busy → ignored. With ALU_MULDIV_EARLY_OUT_EN, Multu 4'h3 × 4'h1 → done 3 cycles after start (2 + 1 iteration), lo=4'h3.
